// File: rtl/buffer_out_pkg.sv
// Shared definitions for the rescale output row buffer: row geometry defaults,
// RGB565 field layout, read-side FSM states, the skid entry format and the
// RGB565 -> RGB888 channel expansion.
package buffer_out_pkg;

  localparam int unsigned ROW_WORDS_DEF      = 320;
  localparam int unsigned ROWS_PER_FRAME_DEF = 240;

  localparam int unsigned R5_W   = 5;
  localparam int unsigned G6_W   = 6;
  localparam int unsigned B5_W   = 5;
  localparam int unsigned R5_LSB = 11;
  localparam int unsigned G6_LSB = 5;
  localparam int unsigned B5_LSB = 0;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STREAM,
    RD_DRAIN
  } rd_state_t;

  // One output beat as held in the skid buffer: {TUSER, TLAST, TDATA}
  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } axis_beat_t;

  // Replicate the top bits of each channel into the vacated LSBs
  function automatic logic [31:0] rgb565_to_rgb888(input logic [15:0] p);
    logic [R5_W-1:0] r;
    logic [G6_W-1:0] g;
    logic [B5_W-1:0] b;
    r = p[R5_LSB +: R5_W];
    g = p[G6_LSB +: G6_W];
    b = p[B5_LSB +: B5_W];
    return {8'h00, r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

endpackage

// File: rtl/buffer_out_skid.sv
// Two-entry output skid FIFO for the AXI4-Stream master side. Entry 0 is the
// head and drives the stream outputs directly, so it only moves on a pop.
module buffer_out_skid
  import buffer_out_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       push,
  input  axis_beat_t din,
  input  logic       pop,
  output axis_beat_t dout,
  output logic [1:0] count
);

  axis_beat_t ent0;
  axis_beat_t ent1;
  logic [1:0] cnt;

  // FIFO storage and occupancy; head is stable unless popped
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= din;
          else             ent1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= din;
          end else begin
            ent0 <= ent1;
            ent1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = ent0;
  assign count = cnt;

endmodule

// File: rtl/buffer_out.sv
// Output-side ping-pong row buffer of the rescale IP. Collects RGB565 pixels
// into two row banks and streams each completed row as 32-bit 0x00RRGGBB beats
// on an AXI4-Stream master, TLAST at end of row, TUSER at start of frame.
module buffer_out
  import buffer_out_pkg::*;
#(
  parameter int unsigned ROW_WORDS      = ROW_WORDS_DEF,
  parameter int unsigned ROWS_PER_FRAME = ROWS_PER_FRAME_DEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_start,
  input  logic [15:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TUSER,
  output logic        row_done_o,
  output logic        frame_done_o,
  output logic        overflow_o
);

  localparam int unsigned PW = $clog2(ROW_WORDS);
  localparam int unsigned AW = $clog2(2 * ROW_WORDS);
  localparam int unsigned CW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(ROW_WORDS - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(ROWS_PER_FRAME - 1);

  logic [15:0]   mem [2*ROW_WORDS];

  logic          wr_bank;
  logic [PW-1:0] wr_ptr;
  logic [1:0]    full;
  logic [1:0]    full_n;
  logic          pixel_ready_q;
  logic          overflow_q;
  logic          wr_en;
  logic          wr_done;
  logic [AW-1:0] wr_addr;

  rd_state_t     rd_state;
  rd_state_t     rd_state_n;
  logic          rd_bank;
  logic [PW-1:0] rd_ptr;
  logic          rd_en;
  logic          rd_done;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data_q;
  logic          rd_vld_q;
  logic          rd_last_q;
  logic          rd_user_q;
  logic [CW-1:0] rd_row;
  logic [CW-1:0] row_cnt;

  axis_beat_t    skid_din;
  axis_beat_t    skid_dout;
  logic [1:0]    skid_cnt;
  logic          pop;
  logic [2:0]    occ;
  logic          space_ok;
  logic          in_flight;
  logic          fs_take;

  // Bank 1 sits directly above bank 0, keeping the array exactly two rows deep
  assign wr_addr = wr_bank ? (AW'(wr_ptr) + AW'(ROW_WORDS)) : AW'(wr_ptr);
  assign rd_addr = rd_bank ? (AW'(rd_ptr) + AW'(ROW_WORDS)) : AW'(rd_ptr);

  assign wr_en   = pixel_valid && pixel_ready_q;
  assign wr_done = wr_en && (wr_ptr == PTR_LAST);
  assign rd_done = rd_en && (rd_ptr == PTR_LAST);

  assign pop = M_AXIS_TVALID && M_AXIS_TREADY;

  // A read issued now lands in the skid next cycle, so count the read already
  // in flight when deciding whether another one still fits
  assign occ      = {1'b0, skid_cnt} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign space_ok = (occ <= 3'd1);

  assign in_flight = (rd_state != RD_IDLE) || (wr_ptr != '0) || (|full) ||
                     rd_vld_q || M_AXIS_TVALID;
  assign fs_take   = frame_start && !in_flight;

  // Row bank storage and synchronous read port; contents survive reset
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= pixel_in;
    if (rd_en) rd_data_q    <= mem[rd_addr];
  end

  // Bank full flags: set by the writer and cleared by the reader, possibly both at once
  always_comb begin
    full_n = full;
    if (wr_done) full_n[wr_bank] = 1'b1;
    if (rd_done) full_n[rd_bank] = 1'b0;
  end

  // Write side pointer, bank, registered ready and sticky overflow
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      wr_bank       <= 1'b0;
      full          <= '0;
      pixel_ready_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      full <= full_n;
      // Registered form of !full[wr_bank], so ready stays low while in reset
      pixel_ready_q <= !full_n[wr_bank ^ wr_done];
      if (wr_en) begin
        wr_ptr <= wr_done ? '0 : wr_ptr + PW'(1);
        if (wr_done) wr_bank <= ~wr_bank;
      end
      if (pixel_valid && !pixel_ready_q) overflow_q <= 1'b1;
    end
  end

  // Read FSM next state and read issue
  always_comb begin
    rd_state_n = rd_state;
    rd_en      = 1'b0;
    unique case (rd_state)
      RD_IDLE: begin
        if (full[rd_bank] && space_ok) begin
          rd_en      = 1'b1;
          rd_state_n = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (space_ok) begin
          rd_en = 1'b1;
          if (rd_ptr == PTR_LAST) rd_state_n = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (pop && skid_dout.last) begin
          rd_state_n = RD_IDLE;
          if (full[rd_bank] && space_ok) begin
            rd_en      = 1'b1;
            rd_state_n = RD_STREAM;
          end
        end
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

  // Read FSM state, read pointer/bank, read-row counter and RAM output tags
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      rd_row    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_user_q <= 1'b0;
    end else begin
      rd_state  <= rd_state_n;
      rd_vld_q  <= rd_en;
      rd_last_q <= rd_done;
      rd_user_q <= rd_en && (rd_ptr == '0) && (rd_row == '0);
      if (rd_en) rd_ptr <= rd_done ? '0 : rd_ptr + PW'(1);
      if (rd_done) begin
        rd_bank <= ~rd_bank;
        rd_row  <= (rd_row == ROW_LAST) ? '0 : rd_row + CW'(1);
      end
      if (fs_take) rd_row <= '0;
    end
  end

  // Output-side row counter advanced by accepted TLAST beats
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      row_cnt <= '0;
    end else if (fs_take) begin
      row_cnt <= '0;
    end else if (row_done_o) begin
      row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + CW'(1);
    end
  end

  assign skid_din = '{user: rd_user_q, last: rd_last_q, data: rgb565_to_rgb888(rd_data_q)};

  buffer_out_skid u_skid (
    .clock  (clock),
    .resetn (resetn),
    .push   (rd_vld_q),
    .din    (skid_din),
    .pop    (pop),
    .dout   (skid_dout),
    .count  (skid_cnt)
  );

  assign M_AXIS_TVALID = (skid_cnt != 2'd0);
  assign M_AXIS_TDATA  = skid_dout.data;
  assign M_AXIS_TLAST  = skid_dout.last;
  assign M_AXIS_TUSER  = skid_dout.user;
  assign row_done_o    = pop && skid_dout.last;
  assign frame_done_o  = row_done_o && (row_cnt == ROW_LAST);
  assign pixel_ready   = pixel_ready_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_buffer_out.sv
// Randomized self-checking bench for buffer_out. A pixel queue plus row/beat
// counters form the reference: every accepted pixel must come out once, in
// order, expanded to RGB888, with TLAST/TUSER/row_done/frame_done at the
// positions implied by the row and frame geometry.
module tb_buffer_out;

  localparam int unsigned RW  = 320;
  localparam int unsigned RPF = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] pixel_in = '0;
  logic        pixel_valid = 1'b0;
  logic        pixel_ready;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TUSER;
  logic        row_done_o;
  logic        frame_done_o;
  logic        overflow_o;

  always #5 clock = ~clock;

  buffer_out #(.ROW_WORDS(RW), .ROWS_PER_FRAME(RPF)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .frame_start   (frame_start),
    .pixel_in      (pixel_in),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .row_done_o    (row_done_o),
    .frame_done_o  (frame_done_o),
    .overflow_o    (overflow_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [15:0] q[$];
  int unsigned beat_idx = 0;
  int unsigned rowi = 0;
  int unsigned n_acc = 0;
  int unsigned n_rowdone = 0;
  int unsigned n_fd = 0;
  int unsigned n_user = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_flags = '0;
  int unsigned rdy_mode = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expand(input logic [15:0] p);
    int unsigned r, g, b;
    r = 32'(p[15:11]);
    g = 32'(p[10:5]);
    b = 32'(p[4:0]);
    r = (r << 3) | (r >> 2);
    g = (g << 2) | (g >> 4);
    b = (b << 3) | (b >> 2);
    return 32'((r << 16) | (g << 8) | b);
  endfunction

  // Downstream ready pattern: 0 = stalled, 1 = always ready, 2 = random 50%
  always @(posedge clock) begin
    #1;
    if (rdy_mode == 0)      M_AXIS_TREADY = 1'b0;
    else if (rdy_mode == 1) M_AXIS_TREADY = 1'b1;
    else                    M_AXIS_TREADY = 1'($urandom_range(0, 1));
  end

  // Monitor: sample mid-cycle, compare every accepted beat against the model
  always @(negedge clock) begin
    logic        hs;
    logic        el;
    logic        eu;
    logic        ef;
    logic        have;
    logic [15:0] p;
    if (resetn) begin
      hs = M_AXIS_TVALID && M_AXIS_TREADY;
      el = (beat_idx == RW - 1);
      eu = (rowi == 0) && (beat_idx == 0);
      ef = el && (rowi == RPF - 1);
      if (pixel_valid && pixel_ready) begin
        q.push_back(pixel_in);
        n_acc++;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
        chk("hold_data", M_AXIS_TDATA, prev_data);
        chk("hold_flags", 32'({M_AXIS_TUSER, M_AXIS_TLAST}), 32'(prev_flags));
      end
      if (hs) begin
        have = (q.size() != 0);
        chk("beat_has_pixel", 32'(have), 32'd1);
        if (have) begin
          p = q.pop_front();
          chk("tdata", M_AXIS_TDATA, expand(p));
        end
        chk("tlast", 32'(M_AXIS_TLAST), 32'(el));
        chk("tuser", 32'(M_AXIS_TUSER), 32'(eu));
        if (M_AXIS_TUSER) n_user++;
        beat_idx++;
        if (beat_idx == RW) begin
          beat_idx = 0;
          rowi = (rowi + 1) % RPF;
        end
      end
      chk("row_done", 32'(row_done_o), 32'(hs && el));
      chk("frame_done", 32'(frame_done_o), 32'(hs && ef));
      if (row_done_o) n_rowdone++;
      if (frame_done_o) n_fd++;
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      prev_flags = {M_AXIS_TUSER, M_AXIS_TLAST};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Present one pixel and hold it until accepted (bounded)
  task automatic push_pixel(input logic [15:0] p);
    pixel_in    = p;
    pixel_valid = 1'b1;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clock);
      if (pixel_ready) begin
        @(posedge clock);
        #1;
        return;
      end
    end
    chk("push_timeout", 32'(pixel_ready), 32'd1);
  endtask

  task automatic send_random_rows(input int unsigned nrows);
    for (int unsigned i = 0; i < nrows * RW; i++) push_pixel(16'($urandom));
    pixel_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t;
    t = 0;
    while ((q.size() != 0 || M_AXIS_TVALID) && t < 20000) begin
      @(negedge clock);
      t++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    sync();
  endtask

  task automatic pulse_frame_start_idle();
    frame_start = 1'b1;
    sync();
    frame_start = 1'b0;
    rowi = 0;
  endtask

  logic [15:0] col_in  [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h0000};
  logic [31:0] col_out [5] = '{32'h00FF0000, 32'h0000FF00, 32'h000000FF, 32'h00FFFFFF, 32'h00000000};

  initial begin
    int unsigned base;
    int unsigned base2;
    int unsigned vcnt;
    int unsigned t;

    // Reset state
    #1;
    chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("rst_tdata", M_AXIS_TDATA, 32'd0);
    chk("rst_flags", 32'({M_AXIS_TUSER, M_AXIS_TLAST}), 32'd0);
    chk("rst_ready", 32'(pixel_ready), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_pulses", 32'({row_done_o, frame_done_o}), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    sync();
    sync();
    chk("ready_after_rst", 32'(pixel_ready), 32'd1);

    // 1: ramp row, latency and back-to-back beats
    rdy_mode = 1;
    for (int unsigned i = 0; i < RW; i++) push_pixel(16'(i));
    pixel_valid = 1'b0;
    @(negedge clock);
    chk("lat_e0", 32'(M_AXIS_TVALID), 32'd0);
    @(negedge clock);
    chk("lat_e1", 32'(M_AXIS_TVALID), 32'd0);
    @(negedge clock);
    chk("lat_e2", 32'(M_AXIS_TVALID), 32'd1);
    vcnt = 0;
    for (int unsigned k = 0; k < RW; k++) begin
      if (k != 0) @(negedge clock);
      if (M_AXIS_TVALID && M_AXIS_TREADY) vcnt++;
    end
    chk("t1_consecutive", vcnt, RW);
    @(negedge clock);
    chk("t1_after_valid", 32'(M_AXIS_TVALID), 32'd0);
    wait_drain();

    // 2: colour expansion at the head of a row
    for (int unsigned i = 0; i < RW; i++) push_pixel(i < 5 ? col_in[i] : 16'($urandom));
    pixel_valid = 1'b0;
    t = 0;
    while (!M_AXIS_TVALID && t < 100) begin
      @(negedge clock);
      t++;
    end
    for (int unsigned k = 0; k < 5; k++) begin
      chk("colour", M_AXIS_TDATA, col_out[k]);
      @(negedge clock);
    end
    wait_drain();

    // 3: random back-pressure over 4 rows, frame_start mid-row is ignored
    rdy_mode = 2;
    base = n_rowdone;
    for (int unsigned i = 0; i < 4 * RW; i++) begin
      frame_start = (i == RW + 100);
      push_pixel(16'($urandom));
    end
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    wait_drain();
    chk("t3_rows", n_rowdone - base, 32'd4);

    // 4: stall downstream, overrun both banks
    pulse_frame_start_idle();
    rdy_mode = 0;
    sync();
    base = n_acc;
    for (int i = 0; i < 700; i++) begin
      pixel_valid = 1'b1;
      pixel_in    = 16'($urandom);
      sync();
    end
    pixel_valid = 1'b0;
    chk("t4_accepted", n_acc - base, 32'd640);
    chk("t4_ready", 32'(pixel_ready), 32'd0);
    chk("t4_ovf", 32'(overflow_o), 32'd1);
    base = n_rowdone;
    rdy_mode = 1;
    wait_drain();
    chk("t4_rows", n_rowdone - base, 32'd2);

    // 5: full frame then first row of the next frame
    pulse_frame_start_idle();
    base  = n_user;
    base2 = n_fd;
    send_random_rows(RPF);
    wait_drain();
    chk("t5_users", n_user - base, 32'd1);
    chk("t5_frame_done", n_fd - base2, 32'd1);
    send_random_rows(1);
    wait_drain();
    chk("t5_next_user", n_user - base, 32'd2);
    chk("t5_fd_once", n_fd - base2, 32'd1);

    // 6: asynchronous reset in the middle of a streaming row
    send_random_rows(1);
    t = 0;
    while (beat_idx < 100 && t < 2000) begin
      sync();
      t++;
    end
    chk("t6_reached_100", 32'(beat_idx >= 100), 32'd1);
    #2;
    resetn = 1'b0;
    q.delete();
    beat_idx = 0;
    rowi     = 0;
    #1;
    chk("t6_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("t6_tdata", M_AXIS_TDATA, 32'd0);
    chk("t6_flags", 32'({M_AXIS_TUSER, M_AXIS_TLAST}), 32'd0);
    chk("t6_ready", 32'(pixel_ready), 32'd0);
    chk("t6_ovf", 32'(overflow_o), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    sync();
    base = n_user;
    send_random_rows(1);
    wait_drain();
    chk("t6_user_again", n_user - base, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
